// File: rtl/cmp_share_pkg.sv
// Shared definitions for the comparator-sharing arbiter: FSM state
// encoding and the bit positions of the three-bit comparator result.
package cmp_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Result bit positions, shared by CMP_Y and Y_OUT
    localparam int Y_GT = 2;
    localparam int Y_EQ = 1;
    localparam int Y_LT = 0;

endpackage

// File: rtl/cmp_share_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder. Starting at ptr_i and
// searching upward with wrap, returns the first requesting index and its
// one-hot form. valid_o is low when no request is set.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [IDW-1:0]   idx_o,
    output logic [N_REQ-1:0] onehot_o,
    output logic             valid_o
);

    // Scan offsets from farthest to nearest so the nearest hit is the last write
    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        valid_o  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
                idx_o    = IDW'((int'(ptr_i) + k) % N_REQ);
                onehot_o = '0;
                onehot_o[(int'(ptr_i) + k) % N_REQ] = 1'b1;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin arbiter/sequencer sharing one external
// magnitude comparator among N_REQ requesters. Each compare takes three
// cycles: IDLE (arbitrate, latch operands), EVAL (comparator settles,
// latch result), FIN (DONE pulse, advance pointer).
// Optional feature macro: CMP_CHECK_EN -- cross-checks the external
// comparator against an internal one and raises a sticky ERR on mismatch.
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int IDW   = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [N_REQ*W-1:0] A_BUS,
    input  logic [N_REQ*W-1:0] B_BUS,
    output logic [N_REQ-1:0]   GNT,
    output logic [W-1:0]       CMP_A,
    output logic [W-1:0]       CMP_B,
    input  logic [2:0]         CMP_Y,
    output logic [2:0]         Y_OUT,
    output logic [IDW-1:0]     RES_ID,
    output logic               DONE,
    output logic               ERR
);

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     win_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [W-1:0]       cmp_a_q, cmp_b_q;
    logic [2:0]         y_q;
    logic [IDW-1:0]     id_q;
    logic               done_q;

    logic [IDW-1:0]     pick_idx;
    logic [N_REQ-1:0]   pick_onehot;
    logic               pick_valid;
    logic               load_ops, load_res, finish;

    logic [W-1:0]       a_arr [N_REQ];
    logic [W-1:0]       b_arr [N_REQ];

    // Unpack the flat operand buses into per-requester slices
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = A_BUS[gi*W +: W];
            assign b_arr[gi] = B_BUS[gi*W +: W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i    (REQ),
        .ptr_i    (ptr_q),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot),
        .valid_o  (pick_valid)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE waits for any request, then a fixed EVAL/FIN pass
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_EVAL;
            ST_EVAL: state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        load_ops = (state_q == ST_IDLE) && pick_valid;
        load_res = (state_q == ST_EVAL);
        finish   = (state_q == ST_FIN);
    end

    // Datapath registers: operand latch, result latch, grant and pointer
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            y_q     <= 3'b000;
            id_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            if (load_ops) begin
                cmp_a_q <= a_arr[pick_idx];
                cmp_b_q <= b_arr[pick_idx];
                gnt_q   <= pick_onehot;
                win_q   <= pick_idx;
            end
            if (load_res) begin
                y_q    <= CMP_Y;
                id_q   <= win_q;
                done_q <= 1'b1;
            end
            if (finish) begin
                done_q <= 1'b0;
                gnt_q  <= '0;
                ptr_q  <= (win_q == IDW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            end
        end
    end

`ifdef CMP_CHECK_EN
    logic [2:0] chk_y;
    logic       err_q;

    // Reference comparison on the registered operands
    always_comb begin
        chk_y       = 3'b000;
        chk_y[Y_GT] = (cmp_a_q >  cmp_b_q);
        chk_y[Y_EQ] = (cmp_a_q == cmp_b_q);
        chk_y[Y_LT] = (cmp_a_q <  cmp_b_q);
    end

    // Sticky error flag, set when the external comparator disagrees in EVAL
    always_ff @(posedge CLK) begin
        if (!RST_N)                          err_q <= 1'b0;
        else if (load_res && chk_y != CMP_Y) err_q <= 1'b1;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign GNT    = gnt_q;
    assign CMP_A  = cmp_a_q;
    assign CMP_B  = cmp_b_q;
    assign Y_OUT  = y_q;
    assign RES_ID = id_q;
    assign DONE   = done_q;

endmodule
